// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

   localparam int RF_RANGE        = 32;
   localparam int RF_AW           = $clog2(RF_RANGE);
   localparam int NUM_SRC         = 2;
   localparam int DEF_MEM_TIMEOUT = 255;

   typedef logic [RF_AW-1:0] reg_addr_t;

   typedef enum logic [1:0] {
      HZ_RUN      = 2'd0,
      HZ_MEM_WAIT = 2'd1,
      HZ_HALT     = 2'd2
   } hz_state_e;

   typedef struct packed {
      logic fwd_mem;
      logic fwd_wb;
      logic load_use;
   } fwd_res_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: decode/EX/MEM info in, stall/flush/forward out.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
   import hazard_ctrl_pkg::*;

   reg_addr_t        id_rs1_addr, id_rs2_addr;
   logic             id_rs1_rd, id_rs2_rd;
   logic             id2ex_reg_wen, id2ex_mem_rd;
   reg_addr_t        id2ex_reg_waddr;
   logic             ex2mem_reg_wen;
   reg_addr_t        ex2mem_reg_waddr;
   logic             ex2mem_ill_instr;
   logic             take_branch;
   logic             lsu_req, lsu_ready;

   logic             id2ex_rs1_forward_from_mem, id2ex_rs1_forward_from_wb;
   logic             id2ex_rs2_forward_from_mem, id2ex_rs2_forward_from_wb;
   logic             if_stall, id_stall, ex_stall;
   logic             if_flush, id_flush;
   logic             core_halted, mem_bus_error;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_rs1_addr, id_rs2_addr, id_rs1_rd, id_rs2_rd,
             id2ex_reg_wen, id2ex_reg_waddr, id2ex_mem_rd,
             ex2mem_reg_wen, ex2mem_reg_waddr, ex2mem_ill_instr,
             take_branch, lsu_req, lsu_ready,
      input  id2ex_rs1_forward_from_mem, id2ex_rs1_forward_from_wb,
             id2ex_rs2_forward_from_mem, id2ex_rs2_forward_from_wb,
             if_stall, id_stall, ex_stall, if_flush, id_flush,
             core_halted, mem_bus_error, stall_cnt
   );

   modport slave (
      input  id_rs1_addr, id_rs2_addr, id_rs1_rd, id_rs2_rd,
             id2ex_reg_wen, id2ex_reg_waddr, id2ex_mem_rd,
             ex2mem_reg_wen, ex2mem_reg_waddr, ex2mem_ill_instr,
             take_branch, lsu_req, lsu_ready,
      output id2ex_rs1_forward_from_mem, id2ex_rs1_forward_from_wb,
             id2ex_rs2_forward_from_mem, id2ex_rs2_forward_from_wb,
             if_stall, id_stall, ex_stall, if_flush, id_flush,
             core_halted, mem_bus_error, stall_cnt
   );

endinterface

// File: rtl/hazard_fwd_cmp.sv
// Per-source comparison of one ID operand against the EX and MEM destinations.
module hazard_fwd_cmp
   import hazard_ctrl_pkg::*;
(
   input  reg_addr_t rs,
   input  logic      rs_rd,
   input  logic      ex_wen,
   input  reg_addr_t ex_waddr,
   input  logic      ex_load,
   input  logic      mem_wen,
   input  reg_addr_t mem_waddr,
   output fwd_res_t  res
);
   logic hit_ex, hit_mem;

   // x0 never forwards; the younger EX result shadows the MEM one
   assign hit_ex  = ex_wen  && (ex_waddr  == rs) && (rs != '0);
   assign hit_mem = mem_wen && (mem_waddr == rs) && (rs != '0);

   assign res.fwd_mem  = rs_rd && hit_ex;
   assign res.fwd_wb   = rs_rd && hit_mem && !hit_ex;
   assign res.load_use = rs_rd && ex_load && hit_ex;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding selects, load-use/LSU stalls, branch flush and halt FSM.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
   parameter int CNT_W       = 32
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz
);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   hz_state_e                state;
   logic [WAIT_W-1:0]        wait_cnt;
   logic                     halted, bus_err;
   logic [CNT_W-1:0]         stall_cnt;
   reg_addr_t [NUM_SRC-1:0]  rs;
   logic [NUM_SRC-1:0]       rs_rd, fwd_mem_n, fwd_wb_n, lu_n;
   logic [NUM_SRC-1:0]       fwd_mem_q, fwd_wb_q;
   logic                     load_use, mem_stall;
   logic                     if_stall, id_stall, ex_stall, if_flush, id_flush;

   assign rs    = {hz.id_rs2_addr, hz.id_rs1_addr};
   assign rs_rd = {hz.id_rs2_rd, hz.id_rs1_rd};

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      fwd_res_t res;
      hazard_fwd_cmp u_cmp (
         .rs        (rs[s]),
         .rs_rd     (rs_rd[s]),
         .ex_wen    (hz.id2ex_reg_wen),
         .ex_waddr  (hz.id2ex_reg_waddr),
         .ex_load   (hz.id2ex_mem_rd),
         .mem_wen   (hz.ex2mem_reg_wen),
         .mem_waddr (hz.ex2mem_reg_waddr),
         .res       (res)
      );
      assign fwd_mem_n[s] = res.fwd_mem;
      assign fwd_wb_n[s]  = res.fwd_wb;
      assign lu_n[s]      = res.load_use;
   end

   assign load_use  = |lu_n;
   assign mem_stall = hz.lsu_req && !hz.lsu_ready;

   always_comb begin
      if_stall = 1'b0;
      id_stall = 1'b0;
      ex_stall = 1'b0;
      if_flush = 1'b0;
      id_flush = 1'b0;
      case (state)
         HZ_RUN: begin
            if (hz.ex2mem_ill_instr) begin
               // halt takes effect from the next cycle
            end else if (mem_stall) begin
               {if_stall, id_stall, ex_stall} = 3'b111;
            end else if (hz.take_branch) begin
               {if_flush, id_flush} = 2'b11;
            end else if (load_use) begin
               {if_stall, id_stall, id_flush} = 3'b111;
            end
         end
         HZ_MEM_WAIT: {if_stall, id_stall, ex_stall} = {3{!hz.lsu_ready}};
         HZ_HALT: begin
            {if_stall, id_stall, ex_stall} = 3'b111;
            id_flush = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= HZ_RUN;
         wait_cnt <= '0;
         halted   <= 1'b0;
         bus_err  <= 1'b0;
      end else begin
         case (state)
            HZ_RUN: begin
               if (hz.ex2mem_ill_instr) begin
                  state  <= HZ_HALT;
                  halted <= 1'b1;
               end else if (mem_stall) begin
                  state    <= HZ_MEM_WAIT;
                  wait_cnt <= '0;
               end
            end
            HZ_MEM_WAIT: begin
               if (hz.lsu_ready) begin
                  state <= HZ_RUN;
               end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                  state   <= HZ_HALT;
                  halted  <= 1'b1;
                  bus_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            HZ_HALT: ;
            default: state <= HZ_RUN;
         endcase
      end
   end

   // selects travel with the ID instruction into EX: hold on stall, zero on bubble
   always_ff @(posedge clk) begin
      if (rst || id_flush) begin
         fwd_mem_q <= '0;
         fwd_wb_q  <= '0;
      end else if (!id_stall) begin
         fwd_mem_q <= fwd_mem_n;
         fwd_wb_q  <= fwd_wb_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (if_stall || id_stall || ex_stall)
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

   assign hz.if_stall                   = if_stall;
   assign hz.id_stall                   = id_stall;
   assign hz.ex_stall                   = ex_stall;
   assign hz.if_flush                   = if_flush;
   assign hz.id_flush                   = id_flush;
   assign hz.id2ex_rs1_forward_from_mem = fwd_mem_q[0];
   assign hz.id2ex_rs1_forward_from_wb  = fwd_wb_q[0];
   assign hz.id2ex_rs2_forward_from_mem = fwd_mem_q[1];
   assign hz.id2ex_rs2_forward_from_wb  = fwd_wb_q[1];
   assign hz.core_halted                = halted;
   assign hz.mem_bus_error              = bus_err;
   assign hz.stall_cnt                  = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios plus a randomized run against a spec-level model of the hazard controller.
module tb_hazard_ctrl;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(32)) hz();
   hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (.clk(clk), .rst(rst), .hz(hz));

   int n_run  = 0;
   int n_fail = 0;

   // {if_stall, id_stall, ex_stall, if_flush, id_flush}
   function automatic logic [4:0] combs();
      return {hz.if_stall, hz.id_stall, hz.ex_stall, hz.if_flush, hz.id_flush};
   endfunction

   // {rs1_mem, rs1_wb, rs2_mem, rs2_wb}
   function automatic logic [3:0] fwds();
      return {hz.id2ex_rs1_forward_from_mem, hz.id2ex_rs1_forward_from_wb,
              hz.id2ex_rs2_forward_from_mem, hz.id2ex_rs2_forward_from_wb};
   endfunction

   function automatic bit fm(logic [4:0] r);
      return hz.id2ex_reg_wen && hz.id2ex_reg_waddr == r && r != 5'd0;
   endfunction

   function automatic bit fw(logic [4:0] r);
      return hz.ex2mem_reg_wen && hz.ex2mem_reg_waddr == r && r != 5'd0 && !fm(r);
   endfunction

   task automatic idle();
      hz.id_rs1_addr = 5'd0; hz.id_rs2_addr = 5'd0;
      hz.id_rs1_rd = 1'b0;   hz.id_rs2_rd = 1'b0;
      hz.id2ex_reg_wen = 1'b0; hz.id2ex_reg_waddr = 5'd0; hz.id2ex_mem_rd = 1'b0;
      hz.ex2mem_reg_wen = 1'b0; hz.ex2mem_reg_waddr = 5'd0; hz.ex2mem_ill_instr = 1'b0;
      hz.take_branch = 1'b0; hz.lsu_req = 1'b0; hz.lsu_ready = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      n_run++;
      if (combs() !== 5'b0) begin n_fail++; $display("FAIL reset_comb got %b want %b", combs(), 5'b0); end
      n_run++;
      if ({fwds(), hz.core_halted, hz.mem_bus_error} !== 6'b0) begin
         n_fail++; $display("FAIL reset_regs got %b want %b", {fwds(), hz.core_halted, hz.mem_bus_error}, 6'b0);
      end
      n_run++;
      if (hz.stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", hz.stall_cnt); end
   endtask

   task automatic test_forward();
      do_reset();
      hz.id2ex_reg_wen = 1'b1; hz.id2ex_reg_waddr = 5'd5;
      hz.id_rs1_addr = 5'd5; hz.id_rs1_rd = 1'b1;
      #1;
      n_run++;
      if (combs() !== 5'b0) begin n_fail++; $display("FAIL fwd_comb got %b want %b", combs(), 5'b0); end
      tick();
      n_run++;
      if (fwds() !== 4'b1000) begin n_fail++; $display("FAIL fwd_mem_x5 got %b want %b", fwds(), 4'b1000); end
      hz.id2ex_reg_waddr = 5'd0; hz.id_rs1_addr = 5'd0;
      tick();
      n_run++;
      if (fwds() !== 4'b0000) begin n_fail++; $display("FAIL fwd_x0 got %b want %b", fwds(), 4'b0000); end
      // MEM-stage writer on rs2, EX writer on a different reg
      hz.id2ex_reg_waddr = 5'd5; hz.ex2mem_reg_wen = 1'b1; hz.ex2mem_reg_waddr = 5'd6;
      hz.id_rs2_addr = 5'd6; hz.id_rs2_rd = 1'b1; hz.id_rs1_addr = 5'd9;
      tick();
      n_run++;
      if (fwds() !== 4'b0001) begin n_fail++; $display("FAIL fwd_wb_rs2 got %b want %b", fwds(), 4'b0001); end
      // both stages write x5: the EX result wins; rs2 not read so no select
      hz.ex2mem_reg_waddr = 5'd5; hz.id_rs1_addr = 5'd5; hz.id_rs2_addr = 5'd5; hz.id_rs2_rd = 1'b0;
      tick();
      n_run++;
      if (fwds() !== 4'b1000) begin n_fail++; $display("FAIL fwd_prio got %b want %b", fwds(), 4'b1000); end
   endtask

   task automatic test_load_use();
      do_reset();
      hz.id2ex_mem_rd = 1'b1; hz.id2ex_reg_wen = 1'b1; hz.id2ex_reg_waddr = 5'd7;
      hz.id_rs2_addr = 5'd7; hz.id_rs2_rd = 1'b1;
      #1;
      n_run++;
      if (combs() !== 5'b11001) begin n_fail++; $display("FAIL lu_comb got %b want %b", combs(), 5'b11001); end
      tick();
      n_run++;
      if (hz.stall_cnt !== 32'd1) begin n_fail++; $display("FAIL lu_cnt got %0d want 1", hz.stall_cnt); end
      n_run++;
      if (fwds() !== 4'b0000) begin n_fail++; $display("FAIL lu_bubble got %b want %b", fwds(), 4'b0000); end
      // load moved to MEM, bubble in EX, consumer still in ID
      hz.id2ex_mem_rd = 1'b0; hz.id2ex_reg_wen = 1'b0; hz.id2ex_reg_waddr = 5'd0;
      hz.ex2mem_reg_wen = 1'b1; hz.ex2mem_reg_waddr = 5'd7;
      #1;
      n_run++;
      if (combs() !== 5'b0) begin n_fail++; $display("FAIL lu_release got %b want %b", combs(), 5'b0); end
      tick();
      n_run++;
      if (fwds() !== 4'b0001) begin n_fail++; $display("FAIL lu_fwd_wb got %b want %b", fwds(), 4'b0001); end
   endtask

   task automatic test_branch_load_use();
      do_reset();
      hz.id2ex_mem_rd = 1'b1; hz.id2ex_reg_wen = 1'b1; hz.id2ex_reg_waddr = 5'd3;
      hz.id_rs1_addr = 5'd3; hz.id_rs1_rd = 1'b1; hz.take_branch = 1'b1;
      #1;
      n_run++;
      if (combs() !== 5'b00011) begin n_fail++; $display("FAIL br_lu_comb got %b want %b", combs(), 5'b00011); end
      tick();
      n_run++;
      if (hz.stall_cnt !== 32'd0) begin n_fail++; $display("FAIL br_cnt got %0d want 0", hz.stall_cnt); end
      // still in RUN: a lone load-use is acted on
      hz.take_branch = 1'b0;
      #1;
      n_run++;
      if (combs() !== 5'b11001) begin n_fail++; $display("FAIL br_run got %b want %b", combs(), 5'b11001); end
   endtask

   task automatic test_lsu_wait();
      do_reset();
      hz.lsu_req = 1'b1; hz.lsu_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_run++;
         if (combs() !== 5'b11100) begin n_fail++; $display("FAIL lsu_wait%0d got %b want %b", i, combs(), 5'b11100); end
         tick();
      end
      hz.lsu_ready = 1'b1;
      #1;
      n_run++;
      if (combs() !== 5'b0) begin n_fail++; $display("FAIL lsu_done got %b want %b", combs(), 5'b0); end
      tick();
      hz.lsu_req = 1'b0;
      n_run++;
      if (hz.stall_cnt !== 32'd3) begin n_fail++; $display("FAIL lsu_cnt got %0d want 3", hz.stall_cnt); end
   endtask

   task automatic test_timeout();
      do_reset();
      hz.lsu_req = 1'b1; hz.lsu_ready = 1'b0;
      // one RUN cycle, then TO wait cycles
      for (int i = 0; i <= TO; i++) begin
         tick();
         n_run++;
         if ({hz.core_halted, hz.mem_bus_error} !== {2{i == TO}}) begin
            n_fail++; $display("FAIL to_flags%0d got %b want %b", i, {hz.core_halted, hz.mem_bus_error}, {2{i == TO}});
         end
      end
      n_run++;
      if (hz.stall_cnt !== 32'(TO + 1)) begin n_fail++; $display("FAIL to_cnt got %0d want %0d", hz.stall_cnt, TO + 1); end
      hz.lsu_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_run++;
         if (combs() !== 5'b11101) begin n_fail++; $display("FAIL to_hold%0d got %b want %b", i, combs(), 5'b11101); end
         tick();
      end
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_run++;
      if ({hz.core_halted, hz.mem_bus_error, combs()} !== 7'b0) begin
         n_fail++; $display("FAIL to_rst got %b want %b", {hz.core_halted, hz.mem_bus_error, combs()}, 7'b0);
      end
   endtask

   task automatic test_illegal();
      do_reset();
      hz.ex2mem_ill_instr = 1'b1;
      tick();
      hz.ex2mem_ill_instr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         hz.lsu_ready = i[0];
         hz.take_branch = i[1];
         #1;
         n_run++;
         if ({hz.core_halted, hz.mem_bus_error, combs()} !== 7'b1011101) begin
            n_fail++; $display("FAIL ill_hold%0d got %b want %b", i, {hz.core_halted, hz.mem_bus_error, combs()}, 7'b1011101);
         end
         tick();
      end
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_run++;
      if ({hz.core_halted, combs()} !== 6'b0) begin n_fail++; $display("FAIL ill_rst got %b want %b", {hz.core_halted, combs()}, 6'b0); end
   endtask

   task automatic test_random();
      bit          m_halt = 0, m_err = 0, m_wait = 0;
      int          m_wn = 0;
      logic [3:0]  m_fwd = '0;
      logic [31:0] m_cnt = '0;
      logic [4:0]  e_c;
      bit          lu, ms;
      do_reset();
      for (int cyc = 0; cyc < 800; cyc++) begin
         rst = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
         hz.id_rs1_addr      = 5'($urandom_range(0, 3));
         hz.id_rs2_addr      = 5'($urandom_range(0, 3));
         hz.id_rs1_rd        = 1'($urandom_range(0, 1));
         hz.id_rs2_rd        = 1'($urandom_range(0, 1));
         hz.id2ex_reg_wen    = 1'($urandom_range(0, 1));
         hz.id2ex_reg_waddr  = 5'($urandom_range(0, 3));
         hz.id2ex_mem_rd     = ($urandom_range(0, 2) == 0);
         hz.ex2mem_reg_wen   = 1'($urandom_range(0, 1));
         hz.ex2mem_reg_waddr = 5'($urandom_range(0, 3));
         hz.ex2mem_ill_instr = ($urandom_range(0, 49) == 0);
         hz.take_branch      = ($urandom_range(0, 4) == 0);
         hz.lsu_req          = ($urandom_range(0, 3) == 0);
         hz.lsu_ready        = 1'($urandom_range(0, 1));
         #1;
         lu = hz.id2ex_mem_rd && hz.id2ex_reg_wen && hz.id2ex_reg_waddr != 5'd0 &&
              ((hz.id_rs1_rd && hz.id_rs1_addr == hz.id2ex_reg_waddr) ||
               (hz.id_rs2_rd && hz.id_rs2_addr == hz.id2ex_reg_waddr));
         ms = hz.lsu_req && !hz.lsu_ready;
         if (m_halt)                   e_c = 5'b11101;
         else if (m_wait)              e_c = hz.lsu_ready ? 5'b00000 : 5'b11100;
         else if (hz.ex2mem_ill_instr) e_c = 5'b00000;
         else if (ms)                  e_c = 5'b11100;
         else if (hz.take_branch)      e_c = 5'b00011;
         else if (lu)                  e_c = 5'b11001;
         else                          e_c = 5'b00000;
         n_run++;
         if (combs() !== e_c) begin n_fail++; $display("FAIL rnd_comb cyc=%0d got %b want %b", cyc, combs(), e_c); end
         if (rst) begin
            m_halt = 0; m_err = 0; m_wait = 0; m_wn = 0; m_fwd = '0; m_cnt = '0;
         end else begin
            if (e_c[0])       m_fwd = '0;
            else if (!e_c[3]) m_fwd = {hz.id_rs1_rd && fm(hz.id_rs1_addr), hz.id_rs1_rd && fw(hz.id_rs1_addr),
                                       hz.id_rs2_rd && fm(hz.id_rs2_addr), hz.id_rs2_rd && fw(hz.id_rs2_addr)};
            if (|e_c[4:2]) m_cnt++;
            if (m_halt) begin
            end else if (m_wait) begin
               if (hz.lsu_ready) m_wait = 0;
               else if (m_wn + 1 == TO) begin m_halt = 1; m_err = 1; m_wait = 0; end
               else m_wn++;
            end else if (hz.ex2mem_ill_instr) begin
               m_halt = 1;
            end else if (ms) begin
               m_wait = 1; m_wn = 0;
            end
         end
         tick();
         n_run++;
         if ({fwds(), hz.core_halted, hz.mem_bus_error} !== {m_fwd, m_halt, m_err}) begin
            n_fail++; $display("FAIL rnd_regs cyc=%0d got %b want %b", cyc, {fwds(), hz.core_halted, hz.mem_bus_error}, {m_fwd, m_halt, m_err});
         end
         n_run++;
         if (hz.stall_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt cyc=%0d got %0d want %0d", cyc, hz.stall_cnt, m_cnt); end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_forward();
      test_load_use();
      test_branch_load_use();
      test_lsu_wait();
      test_timeout();
      test_illegal();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
